fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares one synchronous FIFO write port between N_REQ independent requesters.
- Round-robin arbitration with bounded bursts: a granted requester holds the FIFO until it drops valid, hits MAX_BURST writes, or is reset. Ready is withheld while the FIFO reports full.
- Sits between producer blocks and the existing fifo instance; drives its write and data_in, and observes its full.

Parameters:
- WIDTH, 8, data word width; must equal the FIFO WIDTH.
- N_REQ, 4, number of requesters; 2..16.
- MAX_BURST, 4, maximum writes per grant; 1..256.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester data valid.
- req_data  input  N_REQ*WIDTH  packed; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- fifo_full  input  1  full flag from the FIFO.
- fifo_write  output  1  write strobe to the FIFO.
- fifo_data_in  output  WIDTH  write data to the FIFO.
- gnt_valid  output  1  a grant is active (state BURST).
- gnt_id  output  $clog2(N_REQ)  index of the granted requester; valid when gnt_valid=1.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, rr_ptr=0, burst_cnt=0, gnt_id=0
  - gnt_valid=0, req_ready=0, fifo_write=0, fifo_data_in=0.
- Transfer definition: xfer = gnt_valid & req_valid[gnt_id] & req_ready[gnt_id].
- State IDLE:
  - req_ready=0, fifo_write=0.
  - If any req_valid, pick the first valid index searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
  - Next cycle: gnt_id=winner, rr_ptr=(winner+1) mod N_REQ, burst_cnt=0, state=BURST.
  - Arbitration latency: exactly 1 cycle. No write occurs in the IDLE cycle.
- State BURST:
  - req_ready[gnt_id] = ~fifo_full, combinational; all other ready bits are 0.
  - fifo_write = xfer, combinational.
  - fifo_data_in = req_data of gnt_id, combinational mux. It is don't-care when fifo_write=0 but must not be X.
  - On xfer: burst_cnt increments.
  - xfer with burst_cnt==MAX_BURST-1 -> IDLE (burst limit reached).
  - req_valid[gnt_id]=0 -> IDLE on the next edge; no write that cycle.
  - fifo_full=1 with valid held -> stay in BURST; ready=0, no write, burst_cnt held. Stalls do not count toward MAX_BURST.
- Fairness:
  - After a grant ends, the same requester is searched last.
  - With all N_REQ requesters continuously valid and the FIFO never full, each receives MAX_BURST writes per rotation.
  - Steady throughput is MAX_BURST writes per MAX_BURST+1 cycles.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST+1) bits and never wraps.
  - rr_ptr wraps N_REQ-1 -> 0, including non-power-of-2 N_REQ (e.g. 3 -> 0 when N_REQ=4; 2 -> 0 when N_REQ=3).
- Simultaneous events:
  - Final burst beat plus new requests: move to IDLE first, then arbitrate next cycle.
  - fifo_full rising in the same cycle as a valid: full wins, no write.
- Reset mid-burst: everything returns to reset values immediately (async). Any beat in that cycle is dropped and the requester sees ready=0.
- No combinational path from req_valid to req_ready of a non-granted requester. fifo_full -> req_ready/fifo_write is the only combinational backpressure path.

Decomposition:
- Package fifo_arb_pkg holds:
  - typedef enum logic {IDLE, BURST} arb_state_e
  - function rr_pick(valid vector, ptr) returning the winner index and a found flag.
- Sub-module rr_priority_picker (parameter N_REQ; inputs valid, ptr; outputs idx, found). It is purely combinational and reusable by the future read-side scheduler.
- The top holds the FSM, counter, pointer and data mux.

Test Plan:
- Single requester: req_valid=0001, data 0xFF,0xAA,0xCC,0x11,0x1F with fifo_full=0, MAX_BURST=4 -> gnt_id=0 one cycle after valid. Writes 0xFF,0xAA,0xCC,0x11 on consecutive cycles, 1 idle cycle, then 0x1F. FIFO read-back matches the order.
- All four requesters valid continuously, each sending a unique tag (0x10+i) -> grant order 0,1,2,3,0. Exactly 4 writes per grant, 16 writes in 20 cycles.
- fifo_full held high for 3 cycles mid-burst on requester 2 -> req_ready[2]=0 and fifo_write=0 for those 3 cycles. gnt_id stays 2, burst_cnt is unchanged, and the burst completes after full drops.
- Requester 1 drops valid after 2 beats while requester 3 is valid -> IDLE for 1 cycle, then gnt_id=3. rr_ptr=0 after that grant, so requester 1 is not re-granted before requester 3.
- Assert rst during beat 2 of a burst -> fifo_write, gnt_valid and req_ready go 0 immediately. After release, the first grant goes to the lowest valid index (rr_ptr=0).
- Random valid/full stimulus for 1000 cycles against a reference scoreboard -> per-requester data order is preserved, no write while full, and at most MAX_BURST writes per grant.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the round-robin search used by the FIFO write arbiter
// and any future scheduler that needs the same wrap-around priority pick.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of valid[n-1:0] searching upward from ptr with wrap.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int                   n);
    pick_t res;
    int    j;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (!res.found && valid[4'(j)]) begin
          res.found = 1'b1;
          res.idx   = MAX_IDX_W'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Purely combinational round-robin priority picker over N_REQ valid bits.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(valid), MAX_IDX_W'(ptr), N_REQ);
    idx   = IDX_W'(pick.idx);
    found = pick.found;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among
// N_REQ producers; the FIFO full flag is the only combinational backpressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int N_REQ     = 4,
  parameter  int MAX_BURST = 4,
  localparam int IDX_W     = $clog2(N_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_write,
  output logic [WIDTH-1:0]       fifo_data_in,
  output logic                   gnt_valid,
  output logic [IDX_W-1:0]       gnt_id
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             xfer;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = BURST;
          gnt_id_d    = pick_idx;
          rr_ptr_d    = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        // A full stall leaves the count untouched so stalls never shorten a burst.
        if (!req_valid[gnt_id_q]) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else if (xfer) begin
          if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    gnt_valid    = 1'b0;
    req_ready    = '0;
    xfer         = 1'b0;
    fifo_data_in = '0;
    if (state_q == BURST) begin
      gnt_valid           = 1'b1;
      req_ready[gnt_id_q] = ~fifo_full;
      xfer                = req_valid[gnt_id_q] & ~fifo_full;
      fifo_data_in        = req_data[gnt_id_q*WIDTH +: WIDTH];
    end
    fifo_write = xfer;
    gnt_id     = gnt_id_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences and a
// randomized run checked against a round-robin reference model.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int N_REQ     = 4;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write;
  logic [7:0]  fifo_data_in;
  logic        gnt_valid;
  logic [1:0]  gnt_id;

  int tests = 0;
  int fails = 0;
  logic [7:0] fifo_q[$];

  fifo_wr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .gnt_valid    (gnt_valid),
    .gnt_id       (gnt_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        f;
    logic [3:0]  rdy;
    logic        wr;
    logic        gv;
    logic [1:0]  id;
    logic [7:0]  din;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic f);
    req_valid = v;
    req_data  = d;
    fifo_full = f;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] rdy, input logic wr,
                            input logic gv, input logic [1:0] id);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".write"}, 32'(fifo_write), 32'(wr));
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(gv));
    if (gv) chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
    if (fifo_write) fifo_q.push_back(fifo_data_in);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 32'h0, 1'b0);
    next_cycle();
    check_outs("reset", 4'b0000, 1'b0, 1'b0, 2'd0);
    chk("reset.data_in", 32'(fifo_data_in), 32'h0);
    next_cycle();
    rst = 1'b0;
    fifo_q.delete();
  endtask

  function automatic int ref_pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return 0;
  endfunction

  logic [7:0] exp_bytes[$];
  int         seq[4];
  logic [3:0] p_valid, v;
  logic [31:0] d;
  logic       p_gv, p_wr, exp_gv, exp_wr, f;
  int         p_id, cur_id, m_ptr, beats;

  initial begin
    // single requester 0, then a grant that starts while the FIFO is full
    vecs.push_back('{4'b0001, 32'hFF, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00});
    vecs.push_back('{4'b0001, 32'hFF, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hFF});
    vecs.push_back('{4'b0001, 32'hAA, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hAA});
    vecs.push_back('{4'b0001, 32'hCC, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hCC});
    vecs.push_back('{4'b0001, 32'h11, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h11});
    vecs.push_back('{4'b0001, 32'h1F, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00});
    vecs.push_back('{4'b0001, 32'h1F, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h1F});
    vecs.push_back('{4'b0000, 32'h00, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 8'h00});
    vecs.push_back('{4'b0000, 32'h00, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00});
    vecs.push_back('{4'b0001, 32'h55, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00});
    vecs.push_back('{4'b0001, 32'h55, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h55});
    vecs.push_back('{4'b0001, 32'h55, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h55});
    exp_bytes = '{8'hFF, 8'hAA, 8'hCC, 8'h11, 8'h1F, 8'h55};

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].f);
      check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].wr, vecs[i].gv, vecs[i].id);
      chk($sformatf("vec%0d.data_in", i), 32'(fifo_data_in), 32'(vecs[i].din));
      next_cycle();
    end
    chk("vec.fifo_count", 32'(fifo_q.size()), 32'(exp_bytes.size()));
    foreach (exp_bytes[i])
      if (i < fifo_q.size()) chk($sformatf("vec.fifo[%0d]", i), 32'(fifo_q[i]), 32'(exp_bytes[i]));

    // all four requesters continuously valid
    do_reset();
    drive(4'b1111, 32'h13121110, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_write) fifo_q.push_back(fifo_data_in);
      next_cycle();
    end
    chk("all4.writes", 32'(fifo_q.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      if (k < fifo_q.size()) chk($sformatf("all4.order[%0d]", k), 32'(fifo_q[k]), 32'(8'h10 + k / 4));
    check_outs("all4.idle", 4'b0000, 1'b0, 1'b0, 2'd0);
    next_cycle();
    check_outs("all4.wrap", 4'b0001, 1'b1, 1'b1, 2'd0);

    // fifo_full held for 3 cycles mid-burst on requester 2
    do_reset();
    drive(4'b0100, 32'h00330000, 1'b0);
    check_outs("stall.idle", 4'b0000, 1'b0, 1'b0, 2'd0); next_cycle();
    check_outs("stall.b1", 4'b0100, 1'b1, 1'b1, 2'd2); next_cycle();
    check_outs("stall.b2", 4'b0100, 1'b1, 1'b1, 2'd2); next_cycle();
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_outs($sformatf("stall.full%0d", c), 4'b0000, 1'b0, 1'b1, 2'd2);
      next_cycle();
    end
    fifo_full = 1'b0;
    check_outs("stall.b3", 4'b0100, 1'b1, 1'b1, 2'd2); next_cycle();
    check_outs("stall.b4", 4'b0100, 1'b1, 1'b1, 2'd2); next_cycle();
    check_outs("stall.end", 4'b0000, 1'b0, 1'b0, 2'd0); next_cycle();
    chk("stall.writes", 32'(fifo_q.size()), 32'd4);

    // requester 1 drops valid after 2 beats while requester 3 waits
    do_reset();
    drive(4'b1010, 32'h23002100, 1'b0);
    check_outs("drop.idle", 4'b0000, 1'b0, 1'b0, 2'd0); next_cycle();
    check_outs("drop.b1", 4'b0010, 1'b1, 1'b1, 2'd1); next_cycle();
    check_outs("drop.b2", 4'b0010, 1'b1, 1'b1, 2'd1); next_cycle();
    req_valid = 4'b1000;
    check_outs("drop.gone", 4'b0010, 1'b0, 1'b1, 2'd1); next_cycle();
    check_outs("drop.idle2", 4'b0000, 1'b0, 1'b0, 2'd0); next_cycle();
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      check_outs($sformatf("drop.r3b%0d", c), 4'b1000, 1'b1, 1'b1, 2'd3);
      next_cycle();
    end
    check_outs("drop.idle3", 4'b0000, 1'b0, 1'b0, 2'd0); next_cycle();
    check_outs("drop.regrant", 4'b0010, 1'b1, 1'b1, 2'd1); next_cycle();

    // asynchronous reset during beat 2
    do_reset();
    drive(4'b0001, 32'h000000A5, 1'b0);
    check_outs("arst.idle", 4'b0000, 1'b0, 1'b0, 2'd0); next_cycle();
    check_outs("arst.b1", 4'b0001, 1'b1, 1'b1, 2'd0); next_cycle();
    chk("arst.pre_write", 32'(fifo_write), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst.write", 32'(fifo_write), 32'd0);
    chk("arst.gnt_valid", 32'(gnt_valid), 32'd0);
    chk("arst.ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0101;
    req_data  = 32'h00B700A6;
    next_cycle();
    rst = 1'b0;
    check_outs("arst.idle2", 4'b0000, 1'b0, 1'b0, 2'd0); next_cycle();
    check_outs("arst.lowest", 4'b0001, 1'b1, 1'b1, 2'd0); next_cycle();

    // randomized run against the reference model
    do_reset();
    foreach (seq[i]) seq[i] = 0;
    p_valid = '0; p_gv = 1'b0; p_wr = 1'b0; p_id = 0; cur_id = 0; m_ptr = 0; beats = 0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        v[i] = ($urandom_range(0, 3) != 0);
        d[i*8 +: 8] = {2'(i), 6'(seq[i])};
      end
      f = ($urandom_range(0, 3) == 0);
      drive(v, d, f);
      @(negedge clk);
      if (!p_gv) exp_gv = (p_valid != 4'b0000);
      else       exp_gv = p_valid[p_id] && !(p_wr && beats == MAX_BURST);
      chk($sformatf("rand%0d.gnt_valid", c), 32'(gnt_valid), 32'(exp_gv));
      if (exp_gv && !p_gv) begin
        cur_id = ref_pick(p_valid, m_ptr);
        m_ptr  = (cur_id + 1) % N_REQ;
        beats  = 0;
      end
      if (exp_gv) chk($sformatf("rand%0d.gnt_id", c), 32'(gnt_id), 32'(cur_id));
      exp_wr = exp_gv && v[cur_id] && !f;
      chk($sformatf("rand%0d.ready", c), 32'(req_ready),
          (exp_gv && !f) ? (32'd1 << cur_id) : 32'd0);
      chk($sformatf("rand%0d.write", c), 32'(fifo_write), 32'(exp_wr));
      if (exp_wr) begin
        chk($sformatf("rand%0d.data", c), 32'(fifo_data_in), 32'({2'(cur_id), 6'(seq[cur_id])}));
        seq[cur_id]++;
        beats++;
      end
      p_gv = exp_gv; p_valid = v; p_wr = exp_wr; p_id = cur_id;
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
